// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences each instruction over 3-5 cycles
// with a memory ready handshake, optional JALR/LUI and illegal-opcode trap.
module multicycle_control_unit #(
    parameter bit SUPPORT_JALR    = 1'b1,
    parameter bit SUPPORT_LUI     = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_JALR_LNK = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t state;
    state_t decode_next;
    logic   pc_update;
    logic   branch;

    always_comb begin
        decode_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        case (opcode)
            OP_LOAD, OP_STORE: decode_next = S_MEMADR;
            OP_R:              decode_next = S_EXECR;
            OP_I:              decode_next = S_EXECI;
            OP_JAL:            decode_next = S_JAL;
            OP_BEQ:            decode_next = S_BEQ;
            OP_JALR: if (SUPPORT_JALR) decode_next = S_JALR_ADR;
            OP_LUI:  if (SUPPORT_LUI)  decode_next = S_LUI;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_next;
                S_MEMADR:   state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_JAL,
                S_LUI,
                S_JALR_LNK: state <= S_ALUWB;
                S_JALR_ADR: state <= S_JALR_LNK;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            OP_STORE: imm_src = 3'b001;
            OP_BEQ:   imm_src = 3'b010;
            OP_JAL:   imm_src = 3'b011;
            OP_LUI:   imm_src = 3'b100;
            default:  ;
        endcase
    end

    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR, S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_JAL, S_JALR_LNK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            S_TRAP:  illegal_instr = 1'b1;
            default: ;
        endcase
        pc_write = pc_update | (branch & zero);
        // Reset presents FETCH selects with every strobe held low.
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            mem_req       = 1'b0;
            illegal_instr = 1'b0;
            adr_src       = 1'b0;
            alu_op        = 2'b00;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b10;
            result_src    = 2'b10;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: three parameterisations driven in
// lockstep, expected outputs queued per cycle and checked at negedge.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       req;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [2:0] imm;
        logic       rw;
        logic       ill;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
        obs_t c;
    } ent_t;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] ILL  = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    obs_t       obs [3];
    ent_t       sb [$];
    int         checks = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    // dut0: all features; dut1: discard illegal; dut2: no JALR/LUI
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcw, adr, req, mw, irw, rw, ill;
        logic [1:0] rs, sa, sbs, aop;
        logic [2:0] imm;
        logic [3:0] st;
        multicycle_control_unit #(
            .SUPPORT_JALR(g != 2),
            .SUPPORT_LUI(g != 2),
            .TRAP_ON_ILLEGAL(g != 1)
        ) dut (
            .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
            .mem_ready(mem_ready), .pc_write(pcw), .adr_src(adr),
            .mem_req(req), .mem_write(mw), .ir_write(irw),
            .result_src(rs), .alu_src_a(sa), .alu_src_b(sbs),
            .alu_op(aop), .imm_src(imm), .reg_write(rw),
            .illegal_instr(ill), .state_o(st)
        );
        assign obs[g] = {st, pcw, adr, req, mw, irw, rs, sa, sbs, aop, imm, rw, ill};
    end

    function automatic obs_t ex(input logic [3:0] st, input logic [6:0] op,
                                input logic rdy, input logic z, input logic rst);
        obs_t e;
        e = '0;
        e.st = st;
        case (op)
            SW:      e.imm = 3'b001;
            BEQ:     e.imm = 3'b010;
            JAL:     e.imm = 3'b011;
            LUI:     e.imm = 3'b100;
            default: e.imm = 3'b000;
        endcase
        if (rst) begin
            e.sb = 2'b10;
            e.rs = 2'b10;
            return e;
        end
        case (st)
            4'd0:  begin e.req = 1; e.sb = 2; e.rs = 2; e.irw = rdy; e.pcw = rdy; end
            4'd1:  begin e.sa = 1; e.sb = 1; end
            4'd2:  begin e.sa = 2; e.sb = 1; end
            4'd3:  begin e.req = 1; e.adr = 1; end
            4'd4:  begin e.rs = 1; e.rw = 1; end
            4'd5:  begin e.req = 1; e.mw = 1; e.adr = 1; end
            4'd6:  begin e.sa = 2; e.aop = 2; end
            4'd7:  e.rw = 1;
            4'd8:  begin e.sa = 2; e.sb = 1; e.aop = 2; end
            4'd9:  begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            4'd10: begin e.sa = 2; e.aop = 1; e.pcw = z; end
            4'd11: begin e.sa = 2; e.sb = 1; end
            4'd12: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            4'd13: begin e.sa = 3; e.sb = 1; end
            4'd14: e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input string tag, input logic [6:0] op, input logic rdy,
                        input logic z, input logic rst,
                        input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
        ent_t e;
        obs_t ev [3];
        opcode = op;
        mem_ready = rdy;
        zero = z;
        reset = rst;
        e.a = ex(s0, op, rdy, z, rst);
        e.b = ex(s1, op, rdy, z, rst);
        e.c = ex(s2, op, rdy, z, rst);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        ev = '{e.a, e.b, e.c};
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (obs[i] === ev[i]) else begin
                fails++;
                $error("FAIL %s dut%0d got %h exp %h", tag, i, obs[i], ev[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input string tag, input logic [6:0] op, input logic rdy,
                      input logic z, input logic [3:0] s);
        step(tag, op, rdy, z, 1'b0, s, s, s);
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0;
        zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("rst0", ADD, 0, 0, 1, 0, 0, 0);
        step("rst1", ADD, 1, 0, 1, 0, 0, 0);
        go("add_f", ADD, 1, 0, 0);
        go("add_d", ADD, 1, 0, 1);
        go("add_x", ADD, 1, 0, 6);
        go("add_wb", ADD, 1, 0, 7);
        go("addi_f", ADDI, 1, 0, 0);
        go("addi_d", ADDI, 1, 0, 1);
        go("addi_x", ADDI, 1, 0, 8);
        go("addi_wb", ADDI, 1, 0, 7);
        go("lw_f", LW, 1, 0, 0);
        go("lw_d", LW, 1, 0, 1);
        go("lw_a", LW, 1, 0, 2);
        go("lw_r0", LW, 0, 0, 3);
        go("lw_r1", LW, 0, 0, 3);
        go("lw_r2", LW, 1, 0, 3);
        go("lw_wb", LW, 1, 0, 4);
        go("sw_f", SW, 1, 0, 0);
        go("sw_d", SW, 1, 0, 1);
        go("sw_a", SW, 1, 0, 2);
        go("sw_w0", SW, 0, 0, 5);
        go("sw_w1", SW, 1, 0, 5);
        go("beq1_f", BEQ, 1, 1, 0);
        go("beq1_d", BEQ, 1, 1, 1);
        go("beq1_b", BEQ, 1, 1, 10);
        go("beq0_f", BEQ, 1, 0, 0);
        go("beq0_d", BEQ, 1, 0, 1);
        go("beq0_b", BEQ, 1, 0, 10);
        go("jal_f", JAL, 1, 0, 0);
        go("jal_d", JAL, 1, 0, 1);
        go("jal_j", JAL, 1, 0, 9);
        go("jal_wb", JAL, 1, 0, 7);
        go("f_stall", JALR, 0, 0, 0);
        step("jalr_f", JALR, 1, 0, 0, 0, 0, 0);
        step("jalr_d", JALR, 1, 0, 0, 1, 1, 1);
        step("jalr_a", JALR, 1, 0, 0, 11, 11, 14);
        step("jalr_l", JALR, 1, 0, 0, 12, 12, 14);
        step("jalr_wb", JALR, 1, 0, 0, 7, 7, 14);
        step("rst_trap", JALR, 1, 0, 1, 0, 0, 14);
        step("lui_f", LUI, 1, 0, 0, 0, 0, 0);
        step("lui_d", LUI, 1, 0, 0, 1, 1, 1);
        step("lui_u", LUI, 1, 0, 0, 13, 13, 14);
        step("lui_wb", LUI, 1, 0, 0, 7, 7, 14);
        step("ill_f", ILL, 1, 0, 0, 0, 0, 14);
        step("ill_d", ILL, 1, 0, 0, 1, 1, 14);
        step("ill_t0", ILL, 1, 0, 0, 14, 0, 14);
        step("ill_t1", ILL, 1, 0, 0, 14, 1, 14);
        step("ill_t2", ADD, 1, 0, 0, 14, 0, 14);
        step("rst_ill", ADD, 1, 0, 1, 14, 1, 14);
        go("lw2_f", LW, 1, 0, 0);
        go("lw2_d", LW, 1, 0, 1);
        go("lw2_a", LW, 1, 0, 2);
        go("lw2_r", LW, 0, 0, 3);
        step("rst_mid", LW, 1, 0, 1, 3, 3, 3);
        go("post_rst", LW, 0, 0, 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
